// File: rtl/risc_ctrl_param_if.sv
// Controller <-> datapath bundle: IR/flag/handshake inputs to the controller
// and every strobe, select and status line it drives back.
interface risc_ctrl_param_if #(
    parameter int DATAWIDTH = 8,
    parameter int RAW       = 2
);
    localparam int NUM_REGS = 2 ** RAW;

    logic [DATAWIDTH-1:0] instruction;
    logic                 zero;
    logic                 mem_ready;
    logic                 run;

    logic [NUM_REGS-1:0]  ld_reg;
    logic                 ld_pc;
    logic                 inc_pc;
    logic                 ld_ir;
    logic                 ld_address_reg;
    logic                 ld_reg_y;
    logic                 ld_reg_z;
    logic                 write;
    logic [RAW:0]         sel_bus1_mux;
    logic [1:0]           sel_bus2_mux;
    logic [2:0]           alu_op;
    logic                 halted;
    logic                 error;

    // Controller side
    modport master (
        input  instruction, zero, mem_ready, run,
        output ld_reg, ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y,
               ld_reg_z, write, sel_bus1_mux, sel_bus2_mux, alu_op,
               halted, error
    );

    // Datapath side
    modport slave (
        output instruction, zero, mem_ready, run,
        input  ld_reg, ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y,
               ld_reg_z, write, sel_bus1_mux, sel_bus2_mux, alu_op,
               halted, error
    );
endinterface

// File: rtl/risc_ctrl_param.sv
// Multi-cycle control unit for a small parameterised RISC datapath.
// All outputs are decoded combinationally from the state register and the
// current IR/flag/handshake inputs, so an asynchronous reset drops every
// strobe immediately.
module risc_ctrl_param #(
    parameter int DATAWIDTH = 8,
    parameter int RAW       = 2,
    parameter int OPCODE_W  = 4
) (
    input  logic               clk,
    input  logic               clr,
    risc_ctrl_param_if.master  bus
);
    localparam int NUM_REGS = 2 ** RAW;

    generate
        if (DATAWIDTH < OPCODE_W + 2 * RAW) begin : g_bad_width
            $error("risc_ctrl_param: DATAWIDTH too small for opcode and two register fields");
        end
    endgenerate

    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_RD   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_WR   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_BRZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_BRNZ = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(15);

    localparam logic [RAW:0] SEL_PC   = (RAW + 1)'(NUM_REGS);
    localparam logic [1:0]   BUS2_ALU  = 2'd0;
    localparam logic [1:0]   BUS2_BUS1 = 2'd1;
    localparam logic [1:0]   BUS2_MEM  = 2'd2;

    typedef enum logic [3:0] {
        IDLE, FETCH1, FETCH2, DECODE, EXECUTE, READ1, READ2,
        WRITE1, WRITE2, BRANCH1, BRANCH2, HALT, ERROR
    } state_t;

    state_t state_reg, state_next;
    logic   armed_reg;

    logic [OPCODE_W-1:0] opcode;
    logic [RAW-1:0]      src;
    logic [RAW-1:0]      dest;
    logic [NUM_REGS-1:0] dest_onehot;
    logic [2:0]          alu_code;
    logic                unused_bits;

    assign opcode      = bus.instruction[DATAWIDTH-1 -: OPCODE_W];
    assign src         = bus.instruction[2*RAW-1:RAW];
    assign dest        = bus.instruction[RAW-1:0];
    assign unused_bits = ^bus.instruction;

    // One decoder bit per register keeps ld_reg one-hot by construction
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dest_dec
            assign dest_onehot[gi] = (dest == RAW'(gi));
        end
    endgenerate

    // Datapath ALU function code for the two-operand ALU opcodes
    always_comb begin
        alu_code = 3'd0;
        case (opcode)
            OP_SUB:  alu_code = 3'd1;
            OP_AND:  alu_code = 3'd2;
            OP_OR:   alu_code = 3'd4;
            OP_XOR:  alu_code = 3'd5;
            default: alu_code = 3'd0;
        endcase
    end

    // State register; the first edge after reset release only arms the
    // controller, so the first FETCH1 lands on the second edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg <= IDLE;
            armed_reg <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            state_reg <= armed_reg ? state_next : IDLE;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next          = state_reg;
        bus.ld_reg          = '0;
        bus.ld_pc           = 1'b0;
        bus.inc_pc          = 1'b0;
        bus.ld_ir           = 1'b0;
        bus.ld_address_reg  = 1'b0;
        bus.ld_reg_y        = 1'b0;
        bus.ld_reg_z        = 1'b0;
        bus.write           = 1'b0;
        bus.sel_bus1_mux    = SEL_PC;
        bus.sel_bus2_mux    = BUS2_BUS1;
        bus.alu_op          = 3'd0;
        bus.halted          = 1'b0;
        bus.error           = 1'b0;

        case (state_reg)
            IDLE: state_next = FETCH1;
            FETCH1: begin
                bus.ld_address_reg = 1'b1;
                state_next         = FETCH2;
            end
            FETCH2: begin
                bus.sel_bus2_mux = BUS2_MEM;
                if (bus.mem_ready) begin
                    bus.ld_ir  = 1'b1;
                    bus.inc_pc = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_NOP: state_next = FETCH1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        bus.sel_bus1_mux = {1'b0, src};
                        bus.ld_reg_y     = 1'b1;
                        state_next       = EXECUTE;
                    end
                    OP_NOT: begin
                        bus.sel_bus1_mux = {1'b0, src};
                        bus.sel_bus2_mux = BUS2_ALU;
                        bus.alu_op       = 3'd3;
                        bus.ld_reg_z     = 1'b1;
                        bus.ld_reg       = dest_onehot;
                        state_next       = FETCH1;
                    end
                    OP_RD: begin
                        bus.ld_address_reg = 1'b1;
                        state_next         = READ1;
                    end
                    OP_WR: begin
                        bus.ld_address_reg = 1'b1;
                        state_next         = WRITE1;
                    end
                    OP_BR: begin
                        bus.ld_address_reg = 1'b1;
                        state_next         = BRANCH1;
                    end
                    OP_BRZ, OP_BRNZ: begin
                        // Taken when the flag matches the branch sense
                        if (bus.zero == (opcode == OP_BRZ)) begin
                            bus.ld_address_reg = 1'b1;
                            state_next         = BRANCH1;
                        end else begin
                            bus.inc_pc = 1'b1;
                            state_next = FETCH1;
                        end
                    end
                    OP_HLT:  state_next = HALT;
                    default: state_next = ERROR;
                endcase
            end
            EXECUTE: begin
                bus.sel_bus1_mux = {1'b0, dest};
                bus.sel_bus2_mux = BUS2_ALU;
                bus.alu_op       = alu_code;
                bus.ld_reg_z     = 1'b1;
                bus.ld_reg       = dest_onehot;
                state_next       = FETCH1;
            end
            READ1, WRITE1, BRANCH1: begin
                bus.sel_bus2_mux = BUS2_MEM;
                if (bus.mem_ready) begin
                    bus.ld_address_reg = 1'b1;
                    bus.inc_pc         = (state_reg != BRANCH1);
                    state_next = (state_reg == READ1)  ? READ2  :
                                 (state_reg == WRITE1) ? WRITE2 : BRANCH2;
                end
            end
            READ2: begin
                bus.sel_bus2_mux = BUS2_MEM;
                if (bus.mem_ready) begin
                    bus.ld_reg = dest_onehot;
                    state_next = FETCH1;
                end
            end
            WRITE2: begin
                bus.sel_bus1_mux = {1'b0, src};
                bus.write        = 1'b1;
                if (bus.mem_ready) state_next = FETCH1;
            end
            BRANCH2: begin
                bus.sel_bus2_mux = BUS2_MEM;
                if (bus.mem_ready) begin
                    bus.ld_pc  = 1'b1;
                    state_next = FETCH1;
                end
            end
            HALT: begin
                bus.halted = 1'b1;
                if (bus.run) state_next = FETCH1;
            end
            ERROR: bus.error = 1'b1;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_risc_ctrl_param.sv
// Directed bench for risc_ctrl_param: an 8-bit/4-register instance runs a
// hand-written instruction sequence, a 12-bit/8-register instance runs NOT.
module tb_risc_ctrl_param;
    logic clk;
    logic clr;

    risc_ctrl_param_if #(.DATAWIDTH(8),  .RAW(2)) bus8 ();
    risc_ctrl_param_if #(.DATAWIDTH(12), .RAW(3)) bus12 ();

    risc_ctrl_param #(.DATAWIDTH(8), .RAW(2), .OPCODE_W(4)) dut8 (
        .clk (clk),
        .clr (clr),
        .bus (bus8)
    );

    risc_ctrl_param #(.DATAWIDTH(12), .RAW(3), .OPCODE_W(4)) dut12 (
        .clk (clk),
        .clr (clr),
        .bus (bus12)
    );

    // The wide instance loops on NOT R5 -> R6 with memory always ready
    assign bus12.instruction = 12'h42E;
    assign bus12.mem_ready   = 1'b1;
    assign bus12.zero        = 1'b0;
    assign bus12.run         = 1'b0;

    // {ld_pc, inc_pc, ld_ir, ld_address_reg, ld_reg_y, ld_reg_z, write}
    logic [6:0] s8;
    assign s8 = {bus8.ld_pc, bus8.inc_pc, bus8.ld_ir, bus8.ld_address_reg,
                 bus8.ld_reg_y, bus8.ld_reg_z, bus8.write};

    localparam logic [6:0] S_NONE     = 7'b0000000;
    localparam logic [6:0] S_ADDR     = 7'b0001000;
    localparam logic [6:0] S_FETCH2   = 7'b0110000;
    localparam logic [6:0] S_LDY      = 7'b0000100;
    localparam logic [6:0] S_LDZ      = 7'b0000010;
    localparam logic [6:0] S_INC      = 7'b0100000;
    localparam logic [6:0] S_ADDR_INC = 7'b0101000;
    localparam logic [6:0] S_LDPC     = 7'b1000000;
    localparam logic [6:0] S_WRITE    = 7'b0000001;

    int checks_total  = 0;
    int checks_passed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk FETCH1 and FETCH2 (memory ready), ending in DECODE
    task automatic do_fetch(input string name, input logic [7:0] instr);
        $display("txn %s instr=0x%02h", name, instr);
        bus8.instruction = instr;
        #1;
        check_eq({name, ".f1.strb"}, 32'(s8), 32'(S_ADDR));
        check_eq({name, ".f1.sel1"}, 32'(bus8.sel_bus1_mux), 32'd4);
        tick();
        check_eq({name, ".f2.strb"}, 32'(s8), 32'(S_FETCH2));
        check_eq({name, ".f2.sel2"}, 32'(bus8.sel_bus2_mux), 32'd2);
        tick();
    endtask

    initial begin
        clr              = 1'b0;
        bus8.instruction = 8'h00;
        bus8.zero        = 1'b0;
        bus8.mem_ready   = 1'b1;
        bus8.run         = 1'b0;

        // Held in reset: defaults everywhere
        tick();
        tick();
        check_eq("rst.strb",   32'(s8), 32'(S_NONE));
        check_eq("rst.ldreg",  32'(bus8.ld_reg), 32'd0);
        check_eq("rst.sel1",   32'(bus8.sel_bus1_mux), 32'd4);
        check_eq("rst.sel2",   32'(bus8.sel_bus2_mux), 32'd1);
        check_eq("rst.alu",    32'(bus8.alu_op), 32'd0);
        check_eq("rst.halt",   32'(bus8.halted), 32'd0);
        check_eq("rst.err",    32'(bus8.error), 32'd0);
        check_eq("rst.sel1w",  32'(bus12.sel_bus1_mux), 32'd8);

        // Release: one IDLE cycle, FETCH1 on the second edge
        clr = 1'b1;
        tick();
        check_eq("rel1.strb", 32'(s8), 32'(S_NONE));

        // ADD R1,R2
        tick();
        do_fetch("add", 8'h16);
        check_eq("add.dec.strb", 32'(s8), 32'(S_LDY));
        check_eq("add.dec.sel1", 32'(bus8.sel_bus1_mux), 32'd1);
        check_eq("add.dec.sel2", 32'(bus8.sel_bus2_mux), 32'd1);
        // Wide instance is in DECODE of NOT R5 -> R6 on this same cycle
        check_eq("notw.sel1",  32'(bus12.sel_bus1_mux), 32'd5);
        check_eq("notw.ldreg", 32'(bus12.ld_reg), 32'h40);
        check_eq("notw.alu",   32'(bus12.alu_op), 32'd3);
        check_eq("notw.sel2",  32'(bus12.sel_bus2_mux), 32'd0);
        tick();
        check_eq("add.ex.strb",  32'(s8), 32'(S_LDZ));
        check_eq("add.ex.sel1",  32'(bus8.sel_bus1_mux), 32'd2);
        check_eq("add.ex.sel2",  32'(bus8.sel_bus2_mux), 32'd0);
        check_eq("add.ex.alu",   32'(bus8.alu_op), 32'd0);
        check_eq("add.ex.ldreg", 32'(bus8.ld_reg), 32'b0100);
        tick();

        // XOR R0 -> R1
        do_fetch("xor", 8'hA1);
        check_eq("xor.dec.sel1", 32'(bus8.sel_bus1_mux), 32'd0);
        tick();
        check_eq("xor.ex.alu",   32'(bus8.alu_op), 32'd5);
        check_eq("xor.ex.ldreg", 32'(bus8.ld_reg), 32'b0010);
        tick();

        // NOP: straight back to FETCH1
        do_fetch("nop", 8'h00);
        check_eq("nop.dec.strb", 32'(s8), 32'(S_NONE));
        tick();

        // RD to R3, memory stalls two cycles in READ1
        do_fetch("rd", 8'h53);
        check_eq("rd.dec.strb", 32'(s8), 32'(S_ADDR));
        tick();
        bus8.mem_ready = 1'b0;
        #1;
        check_eq("rd.r1.stall1", 32'(s8), 32'(S_NONE));
        check_eq("rd.r1.sel2",   32'(bus8.sel_bus2_mux), 32'd2);
        tick();
        check_eq("rd.r1.stall2", 32'(s8), 32'(S_NONE));
        bus8.mem_ready = 1'b1;
        #1;
        check_eq("rd.r1.ready",  32'(s8), 32'(S_ADDR_INC));
        tick();
        check_eq("rd.r2.ldreg",  32'(bus8.ld_reg), 32'b1000);
        check_eq("rd.r2.sel2",   32'(bus8.sel_bus2_mux), 32'd2);
        tick();

        // WR from R1, write held through a stalled cycle
        do_fetch("wr", 8'h64);
        tick();
        check_eq("wr.w1.strb", 32'(s8), 32'(S_ADDR_INC));
        tick();
        bus8.mem_ready = 1'b0;
        #1;
        check_eq("wr.w2.stall", 32'(s8), 32'(S_WRITE));
        check_eq("wr.w2.sel1",  32'(bus8.sel_bus1_mux), 32'd1);
        tick();
        bus8.mem_ready = 1'b1;
        #1;
        check_eq("wr.w2.ready", 32'(s8), 32'(S_WRITE));
        tick();
        check_eq("wr.next.strb", 32'(s8), 32'(S_ADDR));

        // BRZ not taken
        do_fetch("brz", 8'h80);
        check_eq("brz.dec.strb", 32'(s8), 32'(S_INC));
        tick();
        check_eq("brz.next.strb", 32'(s8), 32'(S_ADDR));

        // BRNZ taken
        do_fetch("brnz", 8'hB0);
        check_eq("brnz.dec.strb", 32'(s8), 32'(S_ADDR));
        tick();
        check_eq("brnz.b1.strb", 32'(s8), 32'(S_ADDR));
        check_eq("brnz.b1.sel2", 32'(bus8.sel_bus2_mux), 32'd2);
        tick();
        check_eq("brnz.b2.strb", 32'(s8), 32'(S_LDPC));
        tick();

        // HLT: parked for ten cycles, then resume
        do_fetch("hlt", 8'hF0);
        check_eq("hlt.dec.halt", 32'(bus8.halted), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hlt.halted", 32'(bus8.halted), 32'd1);
            check_eq("hlt.strb",   32'(s8), 32'(S_NONE));
        end
        bus8.run = 1'b1;
        tick();
        bus8.run = 1'b0;
        check_eq("hlt.resume.halt", 32'(bus8.halted), 32'd0);
        check_eq("hlt.resume.strb", 32'(s8), 32'(S_ADDR));

        // Illegal opcode 0xC: error sticks through run
        do_fetch("ill", 8'hC0);
        tick();
        check_eq("ill.err", 32'(bus8.error), 32'd1);
        bus8.run = 1'b1;
        tick();
        tick();
        check_eq("ill.err.run",  32'(bus8.error), 32'd1);
        check_eq("ill.strb.run", 32'(s8), 32'(S_NONE));
        bus8.run = 1'b0;
        clr = 1'b0;
        #1;
        check_eq("ill.clr.err",  32'(bus8.error), 32'd0);
        check_eq("ill.clr.sel1", 32'(bus8.sel_bus1_mux), 32'd4);
        clr = 1'b1;
        tick();
        check_eq("ill.idle.strb", 32'(s8), 32'(S_NONE));
        tick();
        check_eq("ill.fetch.strb", 32'(s8), 32'(S_ADDR));

        // Reset between edges while WRITE2 drives write
        do_fetch("wrrst", 8'h64);
        tick();
        tick();
        bus8.mem_ready = 1'b0;
        #1;
        check_eq("wrrst.write", 32'(s8), 32'(S_WRITE));
        #1;
        clr = 1'b0;
        #1;
        check_eq("wrrst.drop", 32'(s8), 32'(S_NONE));
        check_eq("wrrst.sel1", 32'(bus8.sel_bus1_mux), 32'd4);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
